// File: rtl/decoder_proj_pkg.sv
// rtl/decoder_proj_pkg.sv - shared types, io_in field positions and 7-seg table for the decoder project
package decoder_proj_pkg;

    localparam int NIB_W = 4;
    localparam int DEC_W = 1 << NIB_W;

    localparam int EN_BIT  = 6;
    localparam int MODE_HI = 5;
    localparam int MODE_LO = 4;
    localparam int NIB_HI  = 3;
    localparam int NIB_LO  = 0;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'd0,
        MODE_THERMO = 2'd1,
        MODE_PRIO   = 2'd2,
        MODE_GRAY   = 2'd3
    } mode_e;

    // Entry 0 is the rightmost element: {g,f,e,d,c,b,a}, active-high
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [NIB_W-1:0] gray_to_bin(input logic [NIB_W-1:0] g);
        logic [NIB_W-1:0] b;
        b[NIB_W-1] = g[NIB_W-1];
        for (int i = NIB_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/decoder_proj_seg7.sv
// rtl/decoder_proj_seg7.sv - combinational 4-bit value to hex 7-segment pattern lookup
module decoder_proj_seg7
    import decoder_proj_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_HEX[i_val];

endmodule

// File: rtl/decoder_proj_formal_top.sv
// rtl/decoder_proj_formal_top.sv - pad-bus decoder with registered outputs; properties under DECODER_FORMAL_CHECKS_EN
module decoder_proj_formal_top
    import decoder_proj_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       io_in,
    output logic [DEC_W-1:0] dec_out,
    output logic [6:0]       seg_out,
    output logic             valid
);

    logic             w_en;
    mode_e            w_mode;
    logic [NIB_W-1:0] w_nib;
    logic [DEC_W-1:0] w_dec;
    logic [3:0]       w_r;
    logic [1:0]       w_prio_idx;
    logic [6:0]       w_seg;

    logic [DEC_W-1:0] r_dec;
    logic [6:0]       r_seg;
    logic             r_valid;

    assign w_en   = io_in[EN_BIT];
    assign w_mode = mode_e'(io_in[MODE_HI:MODE_LO]);
    assign w_nib  = io_in[NIB_HI:NIB_LO];

    always_comb begin
        w_prio_idx = 2'd0;
        for (int i = 0; i < NIB_W; i++) begin
            if (w_nib[i]) begin
                w_prio_idx = 2'(i);
            end
        end
    end

    always_comb begin
        w_dec = '0;
        case (w_mode)
            MODE_ONEHOT: w_dec = 16'h1 << w_nib;
            MODE_THERMO: w_dec = (16'h1 << w_nib) - 16'h1;
            MODE_PRIO:   w_dec = {13'b0, |w_nib, w_prio_idx};
            MODE_GRAY:   w_dec = {12'b0, gray_to_bin(w_nib)};
            default:     w_dec = '0;
        endcase
    end

    // ONEHOT/THERMO display the raw nibble; PRIO/GRAY display their low result nibble
    assign w_r = (w_mode == MODE_ONEHOT || w_mode == MODE_THERMO) ? w_nib : w_dec[3:0];

    decoder_proj_seg7 u_seg7 (
        .i_val (w_r),
        .o_seg (w_seg)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dec   <= '0;
            r_seg   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_en;
            if (w_en) begin
                r_dec <= w_dec;
                r_seg <= w_seg;
            end
        end
    end

    assign dec_out = r_dec;
    assign seg_out = r_seg;
    assign valid   = r_valid;

`ifdef DECODER_FORMAL_CHECKS_EN
    a_onehot: assert property (@(posedge clock)
        (!reset && w_en && w_mode == MODE_ONEHOT) |=> $onehot(dec_out));
    a_thermo: assert property (@(posedge clock)
        (!reset && w_en && w_mode == MODE_THERMO) |=> $onehot({1'b0, dec_out} + 17'd1));
    a_prio: assert property (@(posedge clock)
        (!reset && w_en && w_mode == MODE_PRIO) |=> (dec_out[15:3] == '0));
    a_gray: assert property (@(posedge clock)
        (!reset && w_en && w_mode == MODE_GRAY) |=> (dec_out[15:4] == '0));
    a_reset_valid: assert property (@(posedge clock) reset |=> !valid);
    a_hold: assert property (@(posedge clock)
        (!reset && !w_en) |=> (!valid && $stable(dec_out) && $stable(seg_out)));
    c_onehot: cover property (@(posedge clock) !reset && w_en && w_mode == MODE_ONEHOT);
    c_thermo: cover property (@(posedge clock) !reset && w_en && w_mode == MODE_THERMO);
    c_prio:   cover property (@(posedge clock) !reset && w_en && w_mode == MODE_PRIO);
    c_gray:   cover property (@(posedge clock) !reset && w_en && w_mode == MODE_GRAY);
`else
`endif

endmodule

// File: tb/tb_decoder_proj_formal_top.sv
// tb/tb_decoder_proj_formal_top.sv - randomized self-checking bench for decoder_proj_formal_top
module tb_decoder_proj_formal_top;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  io_in = '0;
    logic [15:0] dec_out;
    logic [6:0]  seg_out;
    logic        valid;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_dec = '0;
    logic [6:0]  exp_seg = '0;
    logic        exp_valid = 1'b0;

    logic [6:0] seg_tab [16];

    decoder_proj_formal_top dut (
        .clock   (clock),
        .reset   (reset),
        .io_in   (io_in),
        .dec_out (dec_out),
        .seg_out (seg_out),
        .valid   (valid)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] ref_dec(input logic [1:0] mode, input logic [3:0] nib);
        int p;
        case (mode)
            2'd0: return 16'(2 ** int'(nib));
            2'd1: return 16'(2 ** int'(nib) - 1);
            2'd2: begin
                p = -1;
                for (int i = 0; i < 4; i++) if (nib[i]) p = i;
                return (p < 0) ? 16'd0 : 16'(4 + p);
            end
            default: begin
                for (int b = 0; b < 16; b++) begin
                    if (((b ^ (b >> 1)) & 15) == int'(nib)) return 16'(b);
                end
                return 16'hDEAD;
            end
        endcase
    endfunction

    task automatic cycle(input logic rst, input logic [6:0] io);
        logic [15:0] d;
        logic [3:0]  r;
        reset = rst;
        io_in = io;
        @(posedge clock);
        #1;
        if (rst) begin
            exp_dec = '0; exp_seg = '0; exp_valid = 1'b0;
        end else if (io[6]) begin
            d = ref_dec(io[5:4], io[3:0]);
            r = (io[5:4] < 2'd2) ? io[3:0] : d[3:0];
            exp_dec = d; exp_seg = seg_tab[r]; exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 7'h7F);
        cycle(1'b1, 7'h55);
        n_vec++;
        if ({dec_out, seg_out, valid} !== 24'h0) begin
            n_err++;
            $display("FAIL reset: got dec=%h seg=%h valid=%b, want all zero", dec_out, seg_out, valid);
        end
    endtask

    task automatic test_directed();
        logic [6:0]  io_v  [6];
        logic [15:0] dec_v [6];
        logic [6:0]  seg_v [6];
        io_v[0] = 7'b1111010; dec_v[0] = 16'h000C; seg_v[0] = 7'h39;
        io_v[1] = 7'b1000101; dec_v[1] = 16'h0020; seg_v[1] = 7'h6D;
        io_v[2] = 7'b1010011; dec_v[2] = 16'h0007; seg_v[2] = 7'h4F;
        io_v[3] = 7'b1011111; dec_v[3] = 16'h7FFF; seg_v[3] = 7'h71;
        io_v[4] = 7'b1100110; dec_v[4] = 16'h0006; seg_v[4] = 7'h7D;
        io_v[5] = 7'b1100000; dec_v[5] = 16'h0000; seg_v[5] = 7'h3F;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, io_v[i]);
            n_vec++;
            if (dec_out !== dec_v[i] || seg_out !== seg_v[i] || valid !== 1'b1) begin
                n_err++;
                $display("FAIL directed[%0d] io=%b: got dec=%h seg=%h valid=%b, want dec=%h seg=%h valid=1",
                         i, io_v[i], dec_out, seg_out, valid, dec_v[i], seg_v[i]);
            end
        end
    endtask

    task automatic test_hold();
        cycle(1'b0, 7'b1000101);
        cycle(1'b0, 7'b0111010);
        n_vec++;
        if (dec_out !== 16'h0020 || seg_out !== 7'h6D || valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold: got dec=%h seg=%h valid=%b, want dec=0020 seg=6d valid=0", dec_out, seg_out, valid);
        end
        cycle(1'b0, 7'b0010011);
        n_vec++;
        if (dec_out !== 16'h0020 || seg_out !== 7'h6D || valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold2: got dec=%h seg=%h valid=%b, want dec=0020 seg=6d valid=0", dec_out, seg_out, valid);
        end
    endtask

    task automatic test_reset_midop();
        cycle(1'b0, 7'b1111010);
        cycle(1'b1, 7'b1111010);
        n_vec++;
        if ({dec_out, seg_out, valid} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_midop: got dec=%h seg=%h valid=%b, want all zero", dec_out, seg_out, valid);
        end
        cycle(1'b0, 7'b1000101);
        n_vec++;
        if (dec_out !== 16'h0020 || seg_out !== 7'h6D || valid !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset: got dec=%h seg=%h valid=%b, want dec=0020 seg=6d valid=1", dec_out, seg_out, valid);
        end
    endtask

    task automatic test_random();
        logic       rst;
        logic [6:0] io;
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            io  = 7'($urandom);
            cycle(rst, io);
            n_vec++;
            if (dec_out !== exp_dec || seg_out !== exp_seg || valid !== exp_valid) begin
                n_err++;
                $display("FAIL random[%0d] rst=%b io=%b: got dec=%h seg=%h valid=%b, want dec=%h seg=%h valid=%b",
                         i, rst, io, dec_out, seg_out, valid, exp_dec, exp_seg, exp_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] io;
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < 16; n++) begin
                io = {1'b1, 2'(m), 4'(n)};
                cycle(1'b0, io);
                n_vec++;
                if (dec_out !== exp_dec || seg_out !== exp_seg || valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL sweep io=%b: got dec=%h seg=%h valid=%b, want dec=%h seg=%h valid=1",
                             io, dec_out, seg_out, valid, exp_dec, exp_seg);
                end
            end
        end
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        test_reset();
        test_directed();
        test_hold();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
